// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: widths, special encodings, fetch state and opcodes.
// No logic; constants and types only.
// Imported by every stage of the core.
package cpu_isa_pkg;

   localparam int ADDR_W  = 7;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] NOP_OPCODE  = 16'h0000;
   localparam logic [INSTR_W-1:0] HALT_OPCODE = 16'hFFFF;

   // Fetch sequencer: one boot cycle primes the ROM, then free streaming.
   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } fetch_state_e;

   // Major opcode field (instr[15:12]) encodings used by the decoder.
   localparam logic [3:0] OP_LDCA = 4'h0;
   localparam logic [3:0] OP_LDCB = 4'h1;
   localparam logic [3:0] OP_LDMA = 4'h2;
   localparam logic [3:0] OP_LDMB = 4'h3;
   localparam logic [3:0] OP_STMA = 4'h4;
   localparam logic [3:0] OP_ADDA = 4'h5;
   localparam logic [3:0] OP_SUBA = 4'h6;
   localparam logic [3:0] OP_ANDA = 4'h7;
   localparam logic [3:0] OP_ORRA = 4'h8;
   localparam logic [3:0] OP_BRAU = 4'h9;
   localparam logic [3:0] OP_BBZR = 4'hA;
   localparam logic [3:0] OP_BBPL = 4'hB;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a ROM word that lands while the decoder stalls.
// Latency: load visible next cycle; drain/flush empty it next cycle.
// Backpressure: never refuses; the caller only loads when it is empty.
module fetch_skid_buffer #(
   parameter int ADDR_W  = 7,
   parameter int INSTR_W = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               load,
   input  logic               drain,
   input  logic               flush,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [ADDR_W-1:0]  load_addr,
   output logic               full,
   output logic [INSTR_W-1:0] data,
   output logic [ADDR_W-1:0]  addr
);

   logic               full_q, full_d;
   logic [INSTR_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;

   // Next-entry selection: flush beats load beats drain.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      addr_d = addr_q;
      if (flush) begin
         full_d = 1'b0;
      end else if (load) begin
         full_d = 1'b1;
         data_d = load_data;
         addr_d = load_addr;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   // Entry storage.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         full_q <= 1'b0;
         data_q <= '0;
         addr_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         addr_q <= addr_d;
      end
   end

   assign full = full_q;
   assign data = data_q;
   assign addr = addr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives a 1-cycle ROM, feeds the decoder one word/cycle.
// Latency: address issued in t, instruction valid in t+2; taken branch costs one bubble.
// Backpressure: iStall holds the IR and stops issue; one in-flight word parks in a skid.
// Optional halt detection and the oHalted port are built with FETCH_HALT_EN defined.
module fetch_unit #(
   parameter int                        ADDR_W   = cpu_isa_pkg::ADDR_W,
   parameter int                        INSTR_W  = cpu_isa_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0]         RESET_PC = 7'd0
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic [ADDR_W-1:0]  oRom_addr,
   output logic               oRom_en,
   input  logic [INSTR_W-1:0] iRom_data,
   output logic [INSTR_W-1:0] oInstruction,
   output logic               oInstr_valid,
   output logic [ADDR_W-1:0]  oPC,
   input  logic               iStall,
   input  logic               iBranch_taken,
   input  logic [ADDR_W-1:0]  iBranch_dir
`ifdef FETCH_HALT_EN
   ,
   output logic               oHalted
`endif
);

   import cpu_isa_pkg::*;

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
   logic               valid_q, valid_d;
   // inflight_q: a word requested last cycle is on iRom_data now and is wanted.
   logic               inflight_q, inflight_d;
   logic [ADDR_W-1:0]  inflight_addr_q, inflight_addr_d;

   logic               rom_en;
   logic [ADDR_W-1:0]  rom_addr;
   logic               skid_load, skid_drain, skid_flush;
   logic               skid_full;
   logic [INSTR_W-1:0] skid_data;
   logic [ADDR_W-1:0]  skid_addr;
   logic               branch_go;
   logic               halt_hold;

`ifdef FETCH_HALT_EN
   logic               halted_q, halted_d;

   // Halt as soon as the HALT word sits live in the IR, so nothing overwrites it.
   always_comb begin
      halt_hold = halted_q || (valid_q && (ir_q == HALT_OPCODE));
      halted_d  = halt_hold;
   end

   // Sticky halt flag; only Reset clears it.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) halted_q <= 1'b0;
      else       halted_q <= halted_d;
   end

   assign oHalted = halted_q;
`else
   assign halt_hold = 1'b0;
`endif

   assign branch_go = valid_q && !iStall && iBranch_taken;

   // Fetch sequencing: issue, IR load source, skid control and PC update.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_d            = ir_q;
      ir_pc_d         = ir_pc_q;
      valid_d         = valid_q;
      inflight_d      = 1'b0;
      inflight_addr_d = inflight_addr_q;
      rom_en          = 1'b0;
      rom_addr        = pc_q;
      skid_load       = 1'b0;
      skid_drain      = 1'b0;
      skid_flush      = 1'b0;

      case (state_q)
         S_BOOT: begin
            rom_en          = 1'b1;
            pc_d            = pc_q + 1'b1;
            inflight_d      = 1'b1;
            inflight_addr_d = pc_q;
            state_d         = S_RUN;
         end

         default: begin
            if (halt_hold) begin
               // Frozen: no issue, the arriving word is dropped, IR keeps HALT.
               skid_flush = 1'b1;
            end else if (iStall) begin
               if (!valid_q) begin
                  // A bubble never blocks: fill the empty IR even while stalled.
                  if (inflight_q) begin
                     ir_d    = iRom_data;
                     ir_pc_d = inflight_addr_q;
                     valid_d = 1'b1;
                  end
               end else if (inflight_q && !skid_full) begin
                  skid_load = 1'b1;
               end
            end else if (branch_go) begin
               // Redirect; the sequential word arriving now is not loaded.
               rom_en          = 1'b1;
               rom_addr        = iBranch_dir;
               pc_d            = iBranch_dir + 1'b1;
               inflight_d      = 1'b1;
               inflight_addr_d = iBranch_dir;
               skid_flush      = 1'b1;
               valid_d         = 1'b0;
            end else begin
               rom_en          = 1'b1;
               pc_d            = pc_q + 1'b1;
               inflight_d      = 1'b1;
               inflight_addr_d = pc_q;
               if (skid_full) begin
                  ir_d       = skid_data;
                  ir_pc_d    = skid_addr;
                  valid_d    = 1'b1;
                  skid_drain = 1'b1;
               end else if (inflight_q) begin
                  ir_d    = iRom_data;
                  ir_pc_d = inflight_addr_q;
                  valid_d = 1'b1;
               end else begin
                  valid_d = 1'b0;
               end
            end
         end
      endcase
   end

   // Fetch state registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q         <= S_BOOT;
         pc_q            <= RESET_PC;
         ir_q            <= NOP_OPCODE;
         ir_pc_q         <= '0;
         valid_q         <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         ir_q            <= ir_d;
         ir_pc_q         <= ir_pc_d;
         valid_q         <= valid_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
      end
   end

   fetch_skid_buffer #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .Clock     (Clock),
      .Reset     (Reset),
      .load      (skid_load),
      .drain     (skid_drain),
      .flush     (skid_flush),
      .load_data (iRom_data),
      .load_addr (inflight_addr_q),
      .full      (skid_full),
      .data      (skid_data),
      .addr      (skid_addr)
   );

   // Reset forces the enable low immediately, regardless of state.
   assign oRom_en      = rom_en && !Reset;
   assign oRom_addr    = rom_addr;
   assign oInstruction = ir_q;
   assign oInstr_valid = valid_q;
   assign oPC          = ir_pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction decoder.
- Owns the 7-bit program counter and drives a synchronous 128x16 program ROM (1-cycle read latency).
- Presents one 16-bit instruction per cycle to the decoder, with valid/stall handshake.
- Redirects the PC on the decoder's branch_taken/branch_dir outputs with a fixed one-bubble penalty.

Parameters:
- ADDR_W, 7, program counter / ROM address width (matches 7-bit branch target)
- INSTR_W, 16, instruction width
- RESET_PC, 7'd0, first address fetched after reset

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- oRom_addr  out  ADDR_W  ROM read address (combinational from state, PC and branch inputs)
- oRom_en  out  1  ROM read enable; data returns on iRom_data next cycle
- iRom_data  in  INSTR_W  ROM read data, valid the cycle after oRom_en=1
- oInstruction  out  INSTR_W  registered instruction to the decoder
- oInstr_valid  out  1  oInstruction is a live instruction
- oPC  out  ADDR_W  address of oInstruction
- iStall  in  1  decoder cannot accept; hold oInstruction/oInstr_valid
- iBranch_taken  in  1  decoder branch decision for the current oInstruction
- iBranch_dir  in  ADDR_W  branch target

Behaviour:
- Reset values (asynchronous, immediate, including mid-operation):
  - PC=RESET_PC, oInstruction=16'h0000, oInstr_valid=0, oPC=0, oRom_en=0
  - skid empty, inflight=0, state=S_BOOT
  - Fetch sequence restarts from RESET_PC when Reset deasserts.
- States:
  - S_BOOT: one cycle. oRom_en=1, oRom_addr=PC, PC<=PC+1, inflight<=1, next S_RUN.
  - S_RUN: normal streaming.
- Pipeline: address issued in cycle t → iRom_data in t+1 → captured into IR at end of t+1 → oInstr_valid=1 in t+2.
- Steady state:
  - One instruction per cycle, no bubbles.
  - oRom_en=1 and oRom_addr=PC each cycle when not stalled; PC<=PC+1.
- PC wrap: 7'd127+1 = 7'd0, no flag.
- Branch (honoured only when oInstr_valid=1 and iStall=0 and iBranch_taken=1):
  - Same cycle: oRom_addr=iBranch_dir, oRom_en=1, PC<=iBranch_dir+1.
  - The returning in-flight word (sequential PC) is discarded; the skid is cleared.
  - Next cycle: oInstr_valid=0 (exactly one bubble).
  - Following cycle: oInstruction=mem[iBranch_dir], oPC=iBranch_dir.
- iBranch_taken with oInstr_valid=0 or iStall=1: ignored.
- Stall (iStall=1):
  - IR, oPC and oInstr_valid hold; oRom_en=0; PC holds.
  - A word arriving during the first stall cycle (issued the cycle before) goes into the 1-entry skid with its address.
  - Skid full + stall: no further issue, nothing lost.
- Stall release:
  - If the skid is full, IR<=skid, skid empties, and fetch resumes at PC in the same cycle.
  - Throughput returns to 1/cycle with no bubble and no duplicate.
- oInstr_valid=0 with iStall=1: IR may still load (a bubble never blocks).
- Simultaneous iStall=1 and iBranch_taken=1: stall wins, branch is ignored; the decoder re-asserts it after the stall.

Optional Feature:
- Macro: FETCH_HALT_EN
- With the macro:
  - Adds output oHalted (1 bit, reset 0).
  - When an instruction equal to HALT_OPCODE (16'hFFFF) is loaded into IR, the block sets oHalted=1 from the next cycle.
  - oRom_en is forced to 0, PC freezes, and the in-flight word is discarded.
  - The HALT word stays in IR with oInstr_valid=1. Only Reset clears the halt.
- Without the macro: no oHalted port; 16'hFFFF is fetched like any other word.

Decomposition:
- Shared package cpu_isa_pkg:
  - ADDR_W, INSTR_W, NOP encoding 16'h0000, HALT_OPCODE
  - fetch state enum {S_BOOT, S_RUN}
  - existing opcode constants (LDCA…BBPL) also live there
- Sub-module fetch_skid_buffer: 1-entry {data, addr, full}; load/drain/flush inputs; async active-high Reset.

Test Plan:
- Reset release, ROM mem[i]=16'h1000+i → oInstr_valid rises on cycle 2; oInstruction 16'h1000, 16'h1001, 16'h1002… on consecutive cycles; oPC 0,1,2.
- Branch taken at oPC=5 with iBranch_dir=7'd40 → exactly one cycle oInstr_valid=0, then oInstruction=16'h1028, oPC=40, then 41.
- iStall=1 for 3 cycles at oPC=10 → IR holds 16'h100A; after release the sequence 16'h100B, 16'h100C follows with no gap or duplicate.
- PC wrap: branch to 7'd126 → oPC sequence 126, 127, 0, 1.
- iStall=1 together with iBranch_taken=1 → no redirect; after release, a branch taken at the same oPC redirects correctly.
- Reset asserted mid-stream with the skid full → all outputs return to reset values immediately; after release, oInstruction=mem[RESET_PC] on cycle 2.
- With FETCH_HALT_EN, mem[3]=16'hFFFF → oHalted=1 one cycle after oPC=3; oRom_en stays 0 thereafter.
